// File: rtl/imem_responder.sv
// Instruction-memory responder: byte-wide program store with a load port,
// serving 32-bit little-endian fetches assembled from four sequential byte reads.
module imem_responder #(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic          rsp_err,
  output logic          rsp_halt
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    beat;
  logic [IW-1:0] base;
  logic [31:0]   data;
  logic          err;
  logic          halt;

  logic [7:0]    mem [DEPTH];

  logic          misaligned;
  logic          out_of_range;
  logic          accept;
  logic          load_hit;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [7:0]    rd_byte;

  // a+3 is formed one bit wider than the address so requests near 2^AW cannot alias low.
  assign out_of_range = ({1'b0, req_addr} + (AW+1)'(3)) >= (AW+1)'(DEPTH);
  assign misaligned   = (req_addr[1:0] != 2'b00);

  assign req_ready = rst_n && (state == ST_IDLE) && !load_en;
  assign accept    = req_valid && req_ready;

  assign load_hit = load_en && (load_addr < AW'(DEPTH));
  assign wr_idx   = load_addr[IW-1:0];

  // Only in-range aligned requests reach FETCH, so the low index bits suffice.
  assign rd_idx  = base + IW'(beat);
  assign rd_byte = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (load_hit) begin
      mem[wr_idx] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      beat  <= '0;
      base  <= '0;
      data  <= '0;
      err   <= 1'b0;
      halt  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            base <= req_addr[IW-1:0];
            beat <= '0;
            data <= '0;
            halt <= 1'b0;
            if (misaligned || out_of_range) begin
              err   <= 1'b1;
              state <= ST_RESP;
            end else begin
              err   <= 1'b0;
              state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          // Reads sample the array before any same-edge load write lands.
          data[{beat, 3'b000} +: 8] <= rd_byte;
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            state <= ST_RESP;
            halt  <= ({rd_byte, data[23:0]} == 32'h0);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
            data  <= '0;
            err   <= 1'b0;
            halt  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == ST_RESP);
  assign rsp_data  = data;
  assign rsp_err   = err;
  assign rsp_halt  = halt;

endmodule
